// File: rtl/spill_fill_pkg.sv
// spill_fill_pkg: shared state encoding and mode constants for the register spill/fill engine
package spill_fill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPILL_LOAD,
        SPILL_SEND,
        FILL,
        DONE
    } sf_state_t;

    localparam logic MODE_SPILL = 1'b0;
    localparam logic MODE_FILL  = 1'b1;

endpackage

// File: rtl/reg_spill_fill.sv
// reg_spill_fill: streams a register range out of the register file (spill) or writes a byte stream into it (fill)
module reg_spill_fill
    import spill_fill_pkg::*;
#(
    parameter int pw = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [pw:0]   base_addr,
    input  logic [pw:0]   last_addr,
    input  logic          abort,
    output logic [pw:0]   rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          wr_en,
    output logic [pw:0]   wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          busy,
    output logic          done
);

    // Only the low pw bits address a real register; the top bit is always cleared.
    localparam logic [pw:0] AMASK = (pw + 1)'((1 << pw) - 1);

    sf_state_t   state, state_n;
    logic [pw:0] ptr, last;
    logic        send_hs, fill_hs, at_last;

    assign send_hs = (state == SPILL_SEND) && out_valid && out_ready;
    assign fill_hs = (state == FILL) && in_valid && in_ready;
    assign at_last = ptr == last;

    assign rd_addr = ptr;
    assign wr_addr = ptr;
    assign wr_data = in_data;
    assign busy    = state != IDLE;
    assign done    = state == DONE;

    // Next state and the combinational write strobe; abort overrides every other transition.
    always_comb begin
        state_n = state;
        wr_en   = 1'b0;
        case (state)
            IDLE:       if (start) state_n = (mode == MODE_FILL) ? FILL : SPILL_LOAD;
            SPILL_LOAD: state_n = SPILL_SEND;
            SPILL_SEND: if (send_hs) state_n = at_last ? DONE : SPILL_LOAD;
            FILL: begin
                wr_en = fill_hs;
                if (fill_hs && at_last) state_n = DONE;
            end
            DONE:       state_n = IDLE;
            default:    state_n = IDLE;
        endcase
        if (abort && state != IDLE) state_n = IDLE;
    end

    // State, pointer, range end and registered handshake outputs; the strobes follow the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b0;
        end else begin
            state     <= state_n;
            out_valid <= state_n == SPILL_SEND;
            in_ready  <= state_n == FILL;
            if (state == IDLE && start) begin
                ptr  <= base_addr & AMASK;
                last <= last_addr & AMASK;
            end
            if ((send_hs || fill_hs) && !at_last) ptr <= (ptr + 1'b1) & AMASK;
            if (state == SPILL_LOAD) out_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_reg_spill_fill.sv
// tb_reg_spill_fill: table-driven and randomized checks of reg_spill_fill against a register-array model
module tb_reg_spill_fill;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
    logic       out_ready = 1'b0, in_valid = 1'b0;
    logic [3:0] base_addr = '0, last_addr = '0;
    logic [7:0] in_data = '0;
    logic [3:0] rd_addr, wr_addr;
    logic [7:0] rd_data, wr_data, out_data;
    logic       wr_en, out_valid, in_ready, busy, done;

    logic [7:0] regs [16];
    logic [7:0] model [8];
    logic       pre_we = 1'b0;
    logic [3:0] pre_a = '0;
    logic [7:0] pre_d = '0;

    int nchk = 0, nerr = 0;

    typedef struct {
        logic       m;
        logic [3:0] b;
        logic [3:0] l;
        int         rdy;
        int         exp_n;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    always @(posedge clk) begin
        if (wr_en) regs[wr_addr] <= wr_data;
        else if (pre_we) regs[pre_a] <= pre_d;
    end

    reg_spill_fill #(.pw(3), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .base_addr(base_addr), .last_addr(last_addr), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic m, input logic [3:0] b,
                          input logic [3:0] l, input int rdy, input int exp_n);
        int         bm, cyc, last_t, dn;
        logic [7:0] got [$];
        logic [7:0] sent [$];
        logic [7:0] hold;
        logic       stall;
        bm = int'(b[2:0]);
        mode = m; base_addr = b; last_addr = l; start = 1'b1;
        tick;
        start = 1'b0;
        chk({nm, " busy_after_start"}, busy, 1);
        cyc = 0; last_t = -1; dn = 0; stall = 1'b0; hold = '0;
        while (dn == 0 && cyc < 200) begin
            out_ready = (rdy == 0) || (rdy == 1 && cyc % 3 == 0) || (rdy == 2 && $urandom_range(0, 1) == 1);
            in_valid  = (rdy == 0) || (rdy == 1 && cyc % 3 == 0) || (rdy == 2 && $urandom_range(0, 1) == 1);
            in_data   = 8'($urandom);
            #1;
            if (stall) begin
                chk({nm, " stall_data"}, out_data, hold);
                chk({nm, " stall_valid"}, out_valid, 1);
            end
            if (m) begin
                chk({nm, " no_out_valid"}, out_valid, 0);
                chk({nm, " wr_en"}, wr_en, in_valid && in_ready);
                if (in_valid && in_ready) begin
                    chk({nm, " wr_addr"}, wr_addr, (bm + sent.size()) % 8);
                    chk({nm, " wr_data"}, wr_data, in_data);
                    sent.push_back(in_data);
                end
            end else begin
                chk({nm, " no_wr_en"}, wr_en, 0);
                if (out_valid && out_ready) begin
                    if (rdy == 0 && last_t >= 0) chk({nm, " spill_rate"}, cyc - last_t, 2);
                    last_t = cyc;
                    got.push_back(out_data);
                end
            end
            stall = out_valid && !out_ready;
            hold  = out_data;
            if (done) begin
                dn = 1;
                start = 1'b1; mode = ~m; base_addr = '0; last_addr = '0;
            end
            tick;
            start = 1'b0;
            cyc++;
        end
        chk({nm, " done_seen"}, dn, 1);
        chk({nm, " busy_after_done"}, busy, 0);
        chk({nm, " done_once"}, done, 0);
        chk({nm, " in_ready_idle"}, in_ready, 0);
        chk({nm, " out_valid_idle"}, out_valid, 0);
        if (!m) begin
            chk({nm, " spill_count"}, got.size(), exp_n);
            for (int i = 0; i < got.size() && i < exp_n; i++)
                chk($sformatf("%s byte%0d", nm, i), got[i], model[(bm + i) % 8]);
        end else begin
            chk({nm, " fill_count"}, sent.size(), exp_n);
            for (int i = 0; i < sent.size() && i < exp_n; i++) model[(bm + i) % 8] = sent[i];
            for (int a = 0; a < 8; a++) chk($sformatf("%s R%0d", nm, a), regs[a], model[a]);
        end
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        int cnt, cyc;
        logic       rm;
        logic [3:0] rb, rl;
        tbl[0] = '{1'b0, 4'd0,  4'd7, 0, 8};
        tbl[1] = '{1'b0, 4'd2,  4'd4, 1, 3};
        tbl[2] = '{1'b1, 4'd6,  4'd1, 0, 4};
        tbl[3] = '{1'b1, 4'd5,  4'd5, 0, 1};
        tbl[4] = '{1'b0, 4'd13, 4'd9, 2, 5};
        tbl[5] = '{1'b1, 4'd3,  4'd2, 2, 8};
        tbl[6] = '{1'b0, 4'd7,  4'd0, 1, 2};
        tbl[7] = '{1'b1, 4'd0,  4'd7, 1, 8};

        tick;
        tick;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset rd_addr", rd_addr, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            pre_we = 1'b1; pre_a = 4'(i); pre_d = 8'(8'h10 + i);
            model[i] = 8'(8'h10 + i);
            tick;
        end
        pre_we = 1'b0;
        tick;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("row%0d", i), tbl[i].m, tbl[i].b, tbl[i].l, tbl[i].rdy, tbl[i].exp_n);

        mode = 1'b0; base_addr = 4'd0; last_addr = 4'd7; out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        cnt = 0; cyc = 0;
        while (cnt < 3 && cyc < 50) begin
            if (out_valid && out_ready) cnt++;
            tick;
            cyc++;
        end
        chk("abort bytes_before", cnt, 3);
        out_ready = 1'b0;
        tick;
        chk("abort in_send", out_valid, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("abort no_done", done, 0);
        end
        run_op("after_abort", 1'b0, 4'd3, 4'd3, 0, 1);

        mode = 1'b1; base_addr = 4'd2; last_addr = 4'd6; start = 1'b1;
        tick;
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        chk("rst fill in_ready", in_ready, 1);
        tick;
        in_data = 8'hC3;
        tick;
        model[2] = 8'h5A;
        model[3] = 8'hC3;
        in_valid = 1'b0; rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chk("rst busy", busy, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst wr_en", wr_en, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst done", done, 0);
        chk("rst rd_addr", rd_addr, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst no_wr_en", wr_en, 0);
            tick;
        end
        in_valid = 1'b0;
        run_op("refill", 1'b1, 4'd2, 4'd6, 0, 5);

        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom_range(0, 1));
            rb = 4'($urandom);
            rl = 4'($urandom);
            run_op($sformatf("rand%0d", i), rm, rb, rl, $urandom_range(0, 2),
                   ((int'(rl[2:0]) - int'(rb[2:0]) + 8) % 8) + 1);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
